// File: rtl/fft_pkg.sv
// ----------------------------------------------------------------------------
// fft_pkg
// Shared types and constants for the SDF butterfly stage.
//   FFT_DATA_WIDTH / FFT_SIZE / FFT_IN_SIZE : default geometry of the stage
//   OUT_WIDTH : butterfly result width (one bit of growth)
//   IDX_W     : width of block index counters
//   state_t   : butterfly stage sequencing states
//   in_lane_t / out_lane_t : one block of lanes at input / output width
// ----------------------------------------------------------------------------
package fft_pkg;

   localparam int FFT_DATA_WIDTH = 9;
   localparam int FFT_SIZE       = 16;
   localparam int FFT_IN_SIZE    = 16;

   localparam int OUT_WIDTH = FFT_DATA_WIDTH + 1;
   localparam int IDX_W     = (FFT_SIZE > 1) ? $clog2(FFT_SIZE) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SUM   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   typedef logic [FFT_IN_SIZE-1:0][FFT_DATA_WIDTH-1:0] in_lane_t;
   typedef logic [FFT_IN_SIZE-1:0][OUT_WIDTH-1:0]      out_lane_t;

endpackage

// File: rtl/bfly_sdf_stage_if.sv
// ----------------------------------------------------------------------------
// bfly_sdf_stage_if
// Bundle between the delay buffer / downstream stage and the butterfly.
//   master : drives bfly_en, dly_i/q, cur_i/q; observes the dout side
//   slave  : the butterfly stage itself
// Lanes are packed [IN_SIZE-1:0][width-1:0]; every lane is two's complement.
// ----------------------------------------------------------------------------
interface bfly_sdf_stage_if
   import fft_pkg::*;
#(
   parameter int DATA_WIDTH = FFT_DATA_WIDTH,
   parameter int SIZE       = FFT_SIZE,
   parameter int IN_SIZE    = FFT_IN_SIZE
);
   localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;

   logic                                bfly_en;
   logic [IN_SIZE-1:0][DATA_WIDTH-1:0]  dly_i;
   logic [IN_SIZE-1:0][DATA_WIDTH-1:0]  dly_q;
   logic [IN_SIZE-1:0][DATA_WIDTH-1:0]  cur_i;
   logic [IN_SIZE-1:0][DATA_WIDTH-1:0]  cur_q;
   logic [IN_SIZE-1:0][DATA_WIDTH:0]    dout_i;
   logic [IN_SIZE-1:0][DATA_WIDTH:0]    dout_q;
   logic                                dout_valid;
   logic                                dout_sel;
   logic [IW-1:0]                       blk_idx;
   logic                                frame_done;
   logic                                ovf_err;

   modport master (
      output bfly_en, dly_i, dly_q, cur_i, cur_q,
      input  dout_i, dout_q, dout_valid, dout_sel, blk_idx, frame_done, ovf_err
   );

   modport slave (
      input  bfly_en, dly_i, dly_q, cur_i, cur_q,
      output dout_i, dout_q, dout_valid, dout_sel, blk_idx, frame_done, ovf_err
   );

endinterface

// File: rtl/bfly_lane_add.sv
// ----------------------------------------------------------------------------
// bfly_lane_add
// Combinational radix-2 butterfly for one lane of one component.
//   a_i    : delayed sample (signed)
//   b_i    : current sample (signed)
//   sum_o  : a + b, one bit wider, exact
//   diff_o : a - b, one bit wider, exact
// ----------------------------------------------------------------------------
module bfly_lane_add
   import fft_pkg::*;
#(
   parameter int DATA_WIDTH = FFT_DATA_WIDTH
) (
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   output logic [DATA_WIDTH:0]   sum_o,
   output logic [DATA_WIDTH:0]   diff_o
);

   logic [DATA_WIDTH:0] a_ext_s;
   logic [DATA_WIDTH:0] b_ext_s;

   // Sign-extend by one bit so neither result can wrap.
   assign a_ext_s = {a_i[DATA_WIDTH-1], a_i};
   assign b_ext_s = {b_i[DATA_WIDTH-1], b_i};
   assign sum_o   = a_ext_s + b_ext_s;
   assign diff_o  = a_ext_s - b_ext_s;

endmodule

// File: rtl/bfly_sdf_stage.sv
// ----------------------------------------------------------------------------
// bfly_sdf_stage
// Radix-2 SDF butterfly. On each accepted bfly_en the sum block is emitted
// one cycle later and the difference block is parked in a SIZE-deep buffer.
// After SIZE sums the buffer is drained one block per cycle.
//   clk, rstn : clock, asynchronous active-low reset
//   bus       : slave side of bfly_sdf_stage_if (inputs, dout, status)
// ----------------------------------------------------------------------------
module bfly_sdf_stage
   import fft_pkg::*;
#(
   parameter int DATA_WIDTH = FFT_DATA_WIDTH,
   parameter int SIZE       = FFT_SIZE,
   parameter int IN_SIZE    = FFT_IN_SIZE
) (
   input  logic             clk,
   input  logic             rstn,
   bfly_sdf_stage_if.slave  bus
);

   localparam int OW = DATA_WIDTH + 1;
   localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(SIZE - 1);

   typedef logic [IN_SIZE-1:0][OW-1:0] blk_t;

   blk_t        sum_i_s, sum_q_s, diff_i_s, diff_q_s;
   blk_t        mem_i_q [SIZE];
   blk_t        mem_q_q [SIZE];

   state_t      state_q, state_d;
   logic [IW-1:0] cnt_q, cnt_d;
   logic [IW-1:0] rd_q, rd_d;
   blk_t        dout_i_q, dout_i_d;
   blk_t        dout_q_q, dout_q_d;
   logic        valid_q, valid_d;
   logic        sel_q, sel_d;
   logic [IW-1:0] idx_q, idx_d;
   logic        done_q, done_d;
   logic        ovf_q, ovf_d;
   logic        we_s;
   logic [IW-1:0] waddr_s;

   for (genvar j = 0; j < IN_SIZE; j++) begin : g_lane
      bfly_lane_add #(.DATA_WIDTH(DATA_WIDTH)) u_add_i (
         .a_i   (bus.dly_i[j]),
         .b_i   (bus.cur_i[j]),
         .sum_o (sum_i_s[j]),
         .diff_o(diff_i_s[j])
      );
      bfly_lane_add #(.DATA_WIDTH(DATA_WIDTH)) u_add_q (
         .a_i   (bus.dly_q[j]),
         .b_i   (bus.cur_q[j]),
         .sum_o (sum_q_s[j]),
         .diff_o(diff_q_s[j])
      );
   end

   // Next-state, output and buffer-write decode for the IDLE/SUM/DRAIN sequence.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rd_d     = rd_q;
      dout_i_d = dout_i_q;
      dout_q_d = dout_q_q;
      valid_d  = 1'b0;
      sel_d    = sel_q;
      idx_d    = idx_q;
      done_d   = 1'b0;
      ovf_d    = ovf_q;
      we_s     = 1'b0;
      waddr_s  = cnt_q;

      case (state_q)
         IDLE: begin
            if (bus.bfly_en) begin
               dout_i_d = sum_i_s;
               dout_q_d = sum_q_s;
               valid_d  = 1'b1;
               sel_d    = 1'b0;
               idx_d    = '0;
               we_s     = 1'b1;
               waddr_s  = '0;
               if (SIZE == 1) begin
                  state_d = DRAIN;
                  cnt_d   = '0;
                  rd_d    = '0;
               end else begin
                  state_d = SUM;
                  cnt_d   = IW'(1);
               end
            end else begin
               state_d = IDLE;
            end
         end

         SUM: begin
            if (bus.bfly_en) begin
               dout_i_d = sum_i_s;
               dout_q_d = sum_q_s;
               valid_d  = 1'b1;
               sel_d    = 1'b0;
               idx_d    = cnt_q;
               we_s     = 1'b1;
               waddr_s  = cnt_q;
               if (cnt_q == LAST_IDX) begin
                  state_d = DRAIN;
                  cnt_d   = '0;
                  rd_d    = '0;
               end else begin
                  cnt_d   = cnt_q + IW'(1);
               end
            end else begin
               // gap in the enable train: hold position, nothing emitted
               state_d = SUM;
            end
         end

         DRAIN: begin
            // drain runs regardless of bfly_en; an enable here is lost
            dout_i_d = mem_i_q[rd_q];
            dout_q_d = mem_q_q[rd_q];
            valid_d  = 1'b1;
            sel_d    = 1'b1;
            idx_d    = rd_q;
            if (bus.bfly_en) begin
               ovf_d = 1'b1;
            end else begin
               ovf_d = ovf_q;
            end
            if (rd_q == LAST_IDX) begin
               done_d  = 1'b1;
               state_d = IDLE;
               rd_d    = '0;
            end else begin
               rd_d    = rd_q + IW'(1);
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            rd_d    = '0;
         end
      endcase
   end

   // Control and output registers with asynchronous reset.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         rd_q     <= '0;
         dout_i_q <= '0;
         dout_q_q <= '0;
         valid_q  <= 1'b0;
         sel_q    <= 1'b0;
         idx_q    <= '0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rd_q     <= rd_d;
         dout_i_q <= dout_i_d;
         dout_q_q <= dout_q_d;
         valid_q  <= valid_d;
         sel_q    <= sel_d;
         idx_q    <= idx_d;
         done_q   <= done_d;
         ovf_q    <= ovf_d;
      end
   end

   // Difference buffer write port; contents are always rewritten before read.
   always_ff @(posedge clk) begin
      if (we_s) begin
         mem_i_q[waddr_s] <= diff_i_s;
         mem_q_q[waddr_s] <= diff_q_s;
      end
   end

   assign bus.dout_i     = dout_i_q;
   assign bus.dout_q     = dout_q_q;
   assign bus.dout_valid = valid_q;
   assign bus.dout_sel   = sel_q;
   assign bus.blk_idx    = idx_q;
   assign bus.frame_done = done_q;
   assign bus.ovf_err    = ovf_q;

endmodule

// File: tb/tb_bfly_sdf_stage.sv
// ----------------------------------------------------------------------------
// tb_bfly_sdf_stage
// Directed, table-driven bench for bfly_sdf_stage (DATA_WIDTH=9, SIZE=16,
// IN_SIZE=16). Each row gives per-lane input ramps (off + step*lane) and the
// expected outputs as ramps; reset behaviour is checked by hand sequences.
// ----------------------------------------------------------------------------
module tb_bfly_sdf_stage;

   localparam int DW = 9;
   localparam int NB = 16;
   localparam int NL = 16;

   typedef struct {
      bit en;
      int di0, dis, ci, dq0, dqs, cq;
      bit ev, es;
      int ei;
      bit ed, eo;
      int xi0, xis, xq0, xqs;
   } vec_t;

   logic clk;
   logic rstn;
   vec_t tbl [$];
   int   n_vec;
   int   n_err;

   bfly_sdf_stage_if #(.DATA_WIDTH(DW), .SIZE(NB), .IN_SIZE(NL)) bus ();

   bfly_sdf_stage #(.DATA_WIDTH(DW), .SIZE(NB), .IN_SIZE(NL)) dut (
      .clk (clk),
      .rstn(rstn),
      .bus (bus)
   );

   // free-running 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t row(bit en, int di0, int dis, int ci,
                                int dq0, int dqs, int cq,
                                bit ev, bit es, int ei, bit ed, bit eo,
                                int xi0, int xis, int xq0, int xqs);
      vec_t v;
      v.en = en; v.di0 = di0; v.dis = dis; v.ci = ci;
      v.dq0 = dq0; v.dqs = dqs; v.cq = cq;
      v.ev = ev; v.es = es; v.ei = ei; v.ed = ed; v.eo = eo;
      v.xi0 = xi0; v.xis = xis; v.xq0 = xq0; v.xqs = xqs;
      return v;
   endfunction

   // One frame: 16 sums (optionally gapped), 16 drain rows, one idle row.
   // Block b: dly_i = 8b+j, cur_i = -1, dly_q = -4b-j, cur_q = 2.
   task automatic add_frame(input bit gap, input int coll, input bit ovf_pre);
      int blk = 0;
      bit slot = 1'b1;
      while (blk < NB) begin
         if (gap && !slot) begin
            tbl.push_back(row(1'b0, 77, 0, -33, 77, 0, -33,
                              1'b0, 1'b0, 0, 1'b0, ovf_pre, 0, 0, 0, 0));
         end else begin
            tbl.push_back(row(1'b1, 8*blk, 1, -1, -4*blk, -1, 2,
                              1'b1, 1'b0, blk, 1'b0, ovf_pre,
                              8*blk - 1, 1, 2 - 4*blk, -1));
            blk++;
         end
         slot = !slot;
      end
      for (int r = 0; r < NB; r++) begin
         bit o;
         o = ovf_pre || (coll >= 0 && r >= coll);
         tbl.push_back(row(r == coll, 77, 0, -33, 77, 0, -33,
                           1'b1, 1'b1, r, r == NB-1, o,
                           8*r + 1, 1, -2 - 4*r, -1));
      end
      tbl.push_back(row(1'b0, 77, 0, -33, 77, 0, -33,
                        1'b0, 1'b0, 0, 1'b0, ovf_pre || coll >= 0, 0, 0, 0, 0));
   endtask

   task automatic chk(input string name, input int r, input int act, input int exp);
      if (act != exp) begin
         n_err++;
         $display("FAIL %s row %0d: got %0d, want %0d", name, r, act, exp);
      end
   endtask

   task automatic apply(input int r);
      vec_t v;
      v = tbl[r];
      bus.bfly_en = v.en;
      for (int j = 0; j < NL; j++) begin
         bus.dly_i[j] = DW'(v.di0 + v.dis*j);
         bus.cur_i[j] = DW'(v.ci);
         bus.dly_q[j] = DW'(v.dq0 + v.dqs*j);
         bus.cur_q[j] = DW'(v.cq);
      end
      @(posedge clk);
      #1;
      n_vec++;
      chk("dout_valid", r, int'(bus.dout_valid), int'(v.ev));
      chk("frame_done", r, int'(bus.frame_done), int'(v.ed));
      chk("ovf_err",    r, int'(bus.ovf_err),    int'(v.eo));
      if (v.ev) begin
         chk("dout_sel", r, int'(bus.dout_sel), int'(v.es));
         chk("blk_idx",  r, int'(bus.blk_idx),  v.ei);
         for (int j = 0; j < NL; j++) begin
            chk("dout_i", r, int'($signed(bus.dout_i[j])), v.xi0 + v.xis*j);
            chk("dout_q", r, int'($signed(bus.dout_q[j])), v.xq0 + v.xqs*j);
         end
      end
   endtask

   task automatic chk_zero(input string name);
      n_vec++;
      chk({name, " valid"}, -1, int'(bus.dout_valid), 0);
      chk({name, " sel"},   -1, int'(bus.dout_sel),   0);
      chk({name, " idx"},   -1, int'(bus.blk_idx),    0);
      chk({name, " done"},  -1, int'(bus.frame_done), 0);
      chk({name, " ovf"},   -1, int'(bus.ovf_err),    0);
      for (int j = 0; j < NL; j++) begin
         chk({name, " dout_i"}, -1, int'($signed(bus.dout_i[j])), 0);
         chk({name, " dout_q"}, -1, int'($signed(bus.dout_q[j])), 0);
      end
   endtask

   initial begin
      int main_end, stale_lo, stale_hi, fresh_lo;
      n_vec = 0;
      n_err = 0;

      // ---- build the vector table ----
      add_frame(1'b0, -1, 1'b0);                      // contiguous frame
      for (int b = 0; b < NB; b++) begin              // width extremes
         if (b % 2 == 0)
            tbl.push_back(row(1'b1, -256, 0, 255, 255, 0, 255,
                              1'b1, 1'b0, b, 1'b0, 1'b0, -1, 0, 510, 0));
         else
            tbl.push_back(row(1'b1, 255, 0, -256, -256, 0, -256,
                              1'b1, 1'b0, b, 1'b0, 1'b0, -1, 0, -512, 0));
      end
      for (int r = 0; r < NB; r++) begin
         tbl.push_back(row(1'b0, 0, 0, 0, 0, 0, 0,
                           1'b1, 1'b1, r, r == NB-1, 1'b0,
                           (r % 2 == 0) ? -511 : 511, 0, 0, 0));
      end
      tbl.push_back(row(1'b0, 0, 0, 0, 0, 0, 0,
                        1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 0, 0, 0));
      add_frame(1'b1, -1, 1'b0);                      // gapped enables
      add_frame(1'b0, 5, 1'b0);                       // collision at rd=5
      main_end = tbl.size();
      stale_lo = tbl.size();
      for (int b = 0; b < 8; b++) begin               // partial frame, then reset
         tbl.push_back(row(1'b1, 100, 1, -1, 0, 0, 0,
                           1'b1, 1'b0, b, 1'b0, 1'b1, 99, 1, 0, 0));
      end
      stale_hi = tbl.size();
      fresh_lo = tbl.size();
      add_frame(1'b0, -1, 1'b0);                      // fresh frame after reset

      // ---- reset / idle ----
      rstn        = 1'b0;
      bus.bfly_en = 1'b0;
      bus.dly_i   = '0;
      bus.dly_q   = '0;
      bus.cur_i   = '0;
      bus.cur_q   = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_zero("in_reset");
      @(negedge clk);
      rstn = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
         chk_zero("idle");
      end

      // ---- table-driven frames ----
      for (int r = 0; r < main_end; r++) apply(r);
      for (int r = stale_lo; r < stale_hi; r++) apply(r);

      // ---- asynchronous reset mid-frame ----
      bus.bfly_en = 1'b0;
      rstn = 1'b0;
      #2;
      chk_zero("mid_reset");
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
      chk_zero("post_reset");

      for (int r = fresh_lo; r < tbl.size(); r++) apply(r);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/bfly_sdf_stage.md
Name: bfly_sdf_stage

Overview:
- Radix-2 butterfly stage directly downstream of the 16-block delay buffer.
- Consumes the delayed block from the buffer and the current input block on cycles where the buffer flags butterfly-enable.
- Emits sums immediately, stores differences internally, then drains the differences.
- Output is a time-ordered, one-bit-grown stream that feeds the next twiddle/multiply stage.

Parameters:
- DATA_WIDTH, 9: input sample width, signed.
- SIZE, 16: butterfly span in blocks; also the depth of the difference buffer.
- IN_SIZE, 16: parallel lanes per block.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous reset, active-low.
- bfly_en  in  1  butterfly-enable pulse train from the delay buffer; one block pair is valid this cycle.
- dly_i  in  [DATA_WIDTH-1:0] x IN_SIZE  delayed block, I, signed.
- dly_q  in  [DATA_WIDTH-1:0] x IN_SIZE  delayed block, Q, signed.
- cur_i  in  [DATA_WIDTH-1:0] x IN_SIZE  current block, I, signed.
- cur_q  in  [DATA_WIDTH-1:0] x IN_SIZE  current block, Q, signed.
- dout_i  out  [DATA_WIDTH:0] x IN_SIZE  butterfly output, I, signed.
- dout_q  out  [DATA_WIDTH:0] x IN_SIZE  butterfly output, Q, signed.
- dout_valid  out  1  dout holds a valid block.
- dout_sel  out  1  0 = sum block, 1 = difference block.
- blk_idx  out  [$clog2(SIZE)-1:0]  index of the output block within its half.
- frame_done  out  1  one-cycle pulse with the last difference block.
- ovf_err  out  1  sticky flag: bfly_en arrived while draining.

Behaviour:
- Reset (async, rstn=0):
  - All outputs 0; state IDLE; counters 0; ovf_err 0.
  - Difference buffer contents need not be cleared.
  - Reset mid-frame discards all stored differences; the next frame starts fresh.
- Arithmetic, per lane, combinational from the inputs:
  - sum = sext(dly) + sext(cur); diff = sext(dly) - sext(cur).
  - Both are DATA_WIDTH+1 bits. No saturation, no rounding; the result is exact.
- State machine (IDLE, SUM, DRAIN):
  - IDLE: when bfly_en=1, register sum to dout, set dout_valid=1, dout_sel=0, blk_idx=0. Write diff to buffer[0], set cnt=1, go to SUM. If SIZE==1, go straight to DRAIN.
  - SUM: on each bfly_en=1, register sum with blk_idx=cnt and write diff to buffer[cnt]. Gaps (bfly_en=0) are allowed: dout_valid=0 that cycle, state holds. On the SIZE-th enable, go to DRAIN with rd=0.
  - DRAIN: every cycle, unconditionally, output buffer[rd] with dout_valid=1, dout_sel=1, blk_idx=rd, then increment rd. When rd==SIZE-1, pulse frame_done and go to IDLE.
  - DRAIN collision: bfly_en=1 during DRAIN is ignored (no sum, no write) and ovf_err is set. ovf_err clears only on reset.
- Latency: 1 cycle from bfly_en to the sum output.
- Timing: the first difference appears the cycle after the last sum. A continuous frame gives 2*SIZE consecutive valid cycles.
- Back-to-back frames: bfly_en in the same cycle as the frame_done transition is handled in DRAIN and therefore flagged. The first accepted cycle after DRAIN is the one after frame_done.
- Buffer: SIZE x IN_SIZE x 2 x (DATA_WIDTH+1) registers. Write index cnt, read index rd; a single write port and a single read port.
- dout holds its last value when dout_valid=0; consumers must qualify on dout_valid.

Decomposition:
- Package fft_pkg:
  - state enum {IDLE, SUM, DRAIN};
  - localparams OUT_WIDTH = DATA_WIDTH+1 and IDX_W = $clog2(SIZE);
  - lane array typedefs for input and output widths.
- Sub-module bfly_lane_add: purely combinational sum/diff for one lane. Instantiated IN_SIZE x 2, once for I and once for Q.

Test Plan:
- Reset/idle: hold rstn=0, then release with bfly_en=0 -> all outputs 0, dout_valid stays 0.
- Single full frame, SIZE=16:
  - Stimulus: dly lane j = j, cur lane j = -1, 16 contiguous enables.
  - Expect: 16 cycles with sel=0 and lane j = j-1, then 16 cycles with sel=1 and lane j = j+1, blk_idx 0..15 in each half, and frame_done on cycle 32 only.
- Width extremes: dly=-256, cur=255 -> sum=-1, diff=-511. dly=255, cur=-256 -> diff=511. No wrap in the 10-bit result.
- Gapped enables: insert bfly_en=0 every other cycle -> sums appear only on enabled cycles, blk_idx still runs 0..15, DRAIN stays contiguous for 16 cycles.
- Collision: assert bfly_en during DRAIN cycle 5 -> ovf_err=1 and stays set, the drain sequence is unaffected, no sum is emitted.
- Reset mid-frame: pull rstn low after 8 sums, then run a new full frame -> only the new frame's 16 sums and 16 diffs appear, and none of the stale differences are output.
